mcu_arbiter: RTL

- Shares one multi-cycle execute unit (MDU or CMU instance) between two requesting pipeline lanes.
- Accepts at most one operation at a time and picks the winner round-robin.
- Latches the operands and function, sequences the unit, captures its result and returns it to the owning lane.
- Guards the unit with a watchdog, and sits between the execute-stage lane logic and the shared unit.

---
 rtl/mcu_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mcu_arbiter.sv
// ---------------------------------------------------------------------------
// mcu_arbiter
//
// Shares one multi-cycle execute unit (multiply/divide or similar) between two
// pipeline lanes. One operation is in flight at a time; the winner is picked
// round-robin. Operands and function are latched at grant, the unit is
// strobed while BUSY, the result is captured and held for the owning lane
// until it is consumed. A watchdog aborts operations that run too long.
//
// Ports
//   s_clk_i, s_reset_i      clock, synchronous active-high reset
//   s_req_i/flush_i/stall_i per-lane request, flush and stall (bit k = lane k)
//   s_function_i, s_op*_i   per-lane function and operands
//   s_gnt_o                 one-hot acceptance pulse (combinational, IDLE only)
//   s_done_o, s_result_o    result valid (level) for the owner and its value
//   s_err_o                 one-cycle watchdog abort pulse to the owner
//   s_busy_o                arbiter not IDLE
//   s_unit_*_o              compute strobe, latched function/operands, abort
//   s_unit_finished_i/result_i  completion and result from the unit
// ---------------------------------------------------------------------------
module mcu_arbiter #(
   parameter int TIMEOUT = 40,
   parameter int CNT_W   = 8,
   parameter int F_W     = 4
) (
   input  logic                s_clk_i,
   input  logic                s_reset_i,
   input  logic [1:0]          s_req_i,
   input  logic [1:0]          s_flush_i,
   input  logic [1:0]          s_stall_i,
   input  logic [1:0][F_W-1:0] s_function_i,
   input  logic [1:0][31:0]    s_op1_i,
   input  logic [1:0][31:0]    s_op2_i,
   output logic [1:0]          s_gnt_o,
   output logic [1:0]          s_done_o,
   output logic [1:0]          s_err_o,
   output logic [31:0]         s_result_o,
   output logic                s_busy_o,
   output logic                s_unit_compute_o,
   output logic [F_W-1:0]      s_unit_function_o,
   output logic [31:0]         s_unit_op1_o,
   output logic [31:0]         s_unit_op2_o,
   output logic                s_unit_flush_o,
   input  logic                s_unit_finished_i,
   input  logic [31:0]         s_unit_result_i
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_owner;
   logic             r_last;
   logic [CNT_W-1:0] r_cnt;
   logic [F_W-1:0]   r_func;
   logic [31:0]      r_op1;
   logic [31:0]      r_op2;
   logic [31:0]      r_result;

   logic [1:0]       w_elig;
   logic             w_any;
   logic             w_winner;
   logic             w_own_flush;
   logic             w_timeout;
   logic [1:0]       w_gnt;
   logic [1:0]       w_done;
   logic [1:0]       w_err;
   logic             w_unit_flush;

   // Round-robin pick: on a tie the lane that did not win last time goes.
   always_comb begin
      w_elig   = s_req_i & ~s_flush_i;
      w_any    = |w_elig;
      w_winner = (&w_elig) ? ~r_last : w_elig[1];
   end

   assign w_own_flush = s_flush_i[r_owner];
   // Counter is 0 on the first BUSY cycle, so this fires on BUSY cycle TIMEOUT.
   assign w_timeout   = (r_cnt == CNT_W'(TIMEOUT - 1));

   // NOTE: every signal gets a default before the case so no path leaves it
   // unassigned; otherwise synthesis infers a latch.
   always_comb begin
      w_state_nxt  = r_state;
      w_gnt        = 2'b00;
      w_done       = 2'b00;
      w_err        = 2'b00;
      w_unit_flush = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_gnt[w_winner] = 1'b1;
               w_state_nxt     = ST_BUSY;
            end
         end
         ST_BUSY: begin
            // Owner flush beats completion, completion beats the watchdog.
            if (w_own_flush) begin
               w_unit_flush = 1'b1;
               w_state_nxt  = ST_IDLE;
            end else if (s_unit_finished_i) begin
               w_state_nxt  = ST_HOLD;
            end else if (w_timeout) begin
               w_unit_flush     = 1'b1;
               w_err[r_owner]   = 1'b1;
               w_state_nxt      = ST_IDLE;
            end
         end
         ST_HOLD: begin
            w_done[r_owner] = 1'b1;
            if (w_own_flush || !s_stall_i[r_owner]) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: state and datapath registers use non-blocking assignments so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge s_clk_i) begin
      if (s_reset_i) begin
         r_state  <= ST_IDLE;
         r_owner  <= 1'b0;
         r_last   <= 1'b1;
         r_cnt    <= '0;
         // NOTE: the latched operands and result are plain registers, not a
         // RAM, so clearing them on reset is cheap and keeps the outputs at 0.
         r_func   <= '0;
         r_op1    <= '0;
         r_op2    <= '0;
         r_result <= '0;
      end else begin
         r_state <= w_state_nxt;
         unique case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_owner <= w_winner;
                  r_last  <= w_winner;
                  r_func  <= s_function_i[w_winner];
                  r_op1   <= s_op1_i[w_winner];
                  r_op2   <= s_op2_i[w_winner];
                  r_cnt   <= '0;
               end
            end
            ST_BUSY: begin
               r_cnt <= r_cnt + CNT_W'(1);
               if (!w_own_flush && s_unit_finished_i) begin
                  r_result <= s_unit_result_i;
               end
            end
            default: ;
         endcase
      end
   end

   // Pulses are masked during reset so an operation cut by reset ends silently.
   assign s_gnt_o           = w_gnt & {2{~s_reset_i}};
   assign s_err_o           = w_err & {2{~s_reset_i}};
   assign s_unit_flush_o    = w_unit_flush & ~s_reset_i;
   assign s_done_o          = w_done;
   assign s_result_o        = (r_state == ST_HOLD) ? r_result : 32'd0;
   assign s_busy_o          = (r_state != ST_IDLE);
   assign s_unit_compute_o  = (r_state == ST_BUSY);
   assign s_unit_function_o = r_func;
   assign s_unit_op1_o      = r_op1;
   assign s_unit_op2_o      = r_op2;

endmodule
